// File: rtl/param_shift_sequencer_if.sv
// Handshake/data bundle between a shift-unit controller and param_shift_sequencer.
// Latency: none (wires only).
// Backpressure: none; the controller watches busy/done and may pause a sequence with enable.
//
// Signals:
//   mode, enable, start, shamt, inbit, loadval : controller -> shifter
//   regval, so, busy, done                     : shifter -> controller
interface param_shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int SHW   = 3
);
    logic [2:0]       mode;
    logic             enable;
    logic             start;
    logic [SHW-1:0]   shamt;
    logic             inbit;
    logic [WIDTH-1:0] loadval;
    logic [WIDTH-1:0] regval;
    logic             so;
    logic             busy;
    logic             done;

    // Controller side: drives commands, observes register and status.
    modport master (
        output mode, enable, start, shamt, inbit, loadval,
        input  regval, so, busy, done
    );

    // Shifter side.
    modport slave (
        input  mode, enable, start, shamt, inbit, loadval,
        output regval, so, busy, done
    );
endinterface

// File: rtl/param_shift_sequencer.sv
// WIDTH-bit load/hold/shift/rotate register with an N-step "shift by shamt" sequencer.
// Latency: single steps take effect at the edge they are issued; a start with shamt=N
//          steps at the following N edges and pulses done in the cycle after the last step.
// Backpressure: enable=0 freezes register, step count and state (busy stays high).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any sequence and clears everything
//   bus   : slave modport of param_shift_sequencer_if (commands in, regval/so/busy/done out)
module param_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int SHW   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    param_shift_sequencer_if.slave bus
);

    localparam logic [2:0] M_LOAD   = 3'b000;
    localparam logic [2:0] M_HOLD   = 3'b001;
    localparam logic [2:0] M_SHR0   = 3'b010;
    localparam logic [2:0] M_SHL0   = 3'b011;
    localparam logic [2:0] M_SHRIN  = 3'b100;
    localparam logic [2:0] M_SHLIN  = 3'b101;
    localparam logic [2:0] M_ROR    = 3'b110;
    localparam logic [2:0] M_ROL    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [2:0]       cmd_q, cmd_d;

    // One step of the selected operation. Result is {serial_out, new_register}.
    // Load and hold pass the previous serial-out bit through unchanged.
    function automatic logic [WIDTH:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] r,
        input logic             fill,
        input logic             so_prev,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH:0] res;
        case (m)
            M_LOAD:  res = {so_prev, ld};
            M_HOLD:  res = {so_prev, r};
            M_SHR0:  res = {r[0], 1'b0, r[WIDTH-1:1]};
            M_SHL0:  res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            M_SHRIN: res = {r[0], fill, r[WIDTH-1:1]};
            M_SHLIN: res = {r[WIDTH-1], r[WIDTH-2:0], fill};
            M_ROR:   res = {r[0], r[0], r[WIDTH-1:1]};
            M_ROL:   res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            default: res = {so_prev, r};
        endcase
        return res;
    endfunction

    logic [2:0]     step_mode;
    logic [WIDTH:0] step_res;
    logic           seq_req;

    // While sequencing, the latched command drives the step; inbit stays live.
    assign step_mode = (state_q == ST_SHIFT) ? cmd_q : bus.mode;
    assign step_res  = step_fn(step_mode, reg_q, bus.inbit, so_q, bus.loadval);
    // Load/hold with start are plain single steps, never a sequence.
    assign seq_req   = bus.start && (bus.mode[2:1] != 2'b00);

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        so_d    = so_q;
        count_d = count_q;
        cmd_d   = cmd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (seq_req) begin
                        // Accept edge: latch command only, data untouched.
                        cmd_d   = bus.mode;
                        count_d = bus.shamt;
                        if (bus.shamt != '0) begin
                            state_d = ST_SHIFT;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        {so_d, reg_d} = step_res;
                    end
                end
            end

            ST_SHIFT: begin
                busy_d = 1'b1;
                if (bus.enable) begin
                    {so_d, reg_d} = step_res;
                    count_d       = count_q - SHW'(1);
                    if (count_q == SHW'(1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            cmd_q   <= M_HOLD;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus.regval = reg_q;
    assign bus.so     = so_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_param_shift_sequencer.sv
// Directed plus randomized bench for param_shift_sequencer against a step/queue-level model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: enable is dropped both in directed steps and randomly.
module tb_param_shift_sequencer;

    localparam int W = 4;
    localparam int S = 3;

    logic clk;
    logic rst_n;

    param_shift_sequencer_if #(.WIDTH(W), .SHW(S)) bus ();

    param_shift_sequencer #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register value, serial-out, and "steps still owed".
    logic [W-1:0] m_reg;
    logic         m_so;
    logic [2:0]   m_cmd;
    int           m_rem;
    bit           m_busy;
    bit           m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".regval"}, 32'(bus.regval), 32'(m_reg));
        chk({tag, ".so"},     32'(bus.so),     32'(m_so));
        chk({tag, ".busy"},   32'(bus.busy),   32'(m_busy));
        chk({tag, ".done"},   32'(bus.done),   32'(m_done));
    endtask

    task automatic model_reset();
        m_reg  = '0;
        m_so   = 1'b0;
        m_cmd  = 3'b001;
        m_rem  = 0;
        m_busy = 0;
        m_done = 0;
    endtask

    // Arithmetic description of one operation on the model register.
    task automatic model_apply(input logic [2:0] md);
        case (md)
            3'd0: m_reg = bus.loadval;
            3'd1: ;
            3'd2, 3'd4, 3'd6: begin
                logic fill;
                fill  = (md == 3'd2) ? 1'b0 : (md == 3'd4) ? bus.inbit : m_reg[0];
                m_so  = m_reg[0];
                m_reg = m_reg >> 1;
                if (fill) m_reg[W-1] = 1'b1;
            end
            default: begin
                logic fill;
                fill  = (md == 3'd3) ? 1'b0 : (md == 3'd5) ? bus.inbit : m_reg[W-1];
                m_so  = m_reg[W-1];
                m_reg = m_reg << 1;
                if (fill) m_reg[0] = 1'b1;
            end
        endcase
    endtask

    task automatic model_edge();
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (bus.enable) begin
                model_apply(m_cmd);
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (bus.enable) begin
            if (bus.start && bus.mode >= 3'd2) begin
                m_cmd = bus.mode;
                m_rem = int'(bus.shamt);
                if (m_rem == 0) m_done = 1;
                else            m_busy = 1;
            end else begin
                model_apply(bus.mode);
            end
        end
    endtask

    task automatic drive(input logic [2:0] md, input logic en, input logic st,
                         input logic [S-1:0] sh, input logic ib, input logic [W-1:0] ld);
        bus.mode    = md;
        bus.enable  = en;
        bus.start   = st;
        bus.shamt   = sh;
        bus.inbit   = ib;
        bus.loadval = ld;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
        chk({tag, ".excl"}, 32'(bus.busy & bus.done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'd1, 1'b0, 1'b0, '0, 1'b0, '0);
        model_reset();
        #12;
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load and hold.
        drive(3'd0, 1'b1, 1'b0, '0, 1'b0, 4'b1010);
        cycle("load");
        chk("load_const", 32'(bus.regval), 32'hA);
        drive(3'd1, 1'b1, 1'b0, '0, 1'b0, 4'b0000);
        repeat (3) cycle("hold");
        chk("hold_const", 32'(bus.regval), 32'hA);

        // Single steps.
        drive(3'd2, 1'b1, 1'b0, '0, 1'b0, 4'b0000);
        cycle("shr0");
        chk("shr0_const", 32'(bus.regval), 32'h5);
        drive(3'd0, 1'b1, 1'b0, '0, 1'b0, 4'b1010);
        cycle("reload");
        drive(3'd5, 1'b1, 1'b0, '0, 1'b1, 4'b0000);
        cycle("shlin");
        chk("shlin_const", 32'({bus.so, bus.regval}), 32'h15);
        drive(3'd3, 1'b1, 1'b0, '0, 1'b0, 4'b0000);
        cycle("shl0");
        chk("shl0_const", 32'({bus.so, bus.regval}), 32'h0A);

        // Rotate-left sequence of 3, with noise on mode/loadval while busy.
        drive(3'd0, 1'b1, 1'b0, '0, 1'b0, 4'b1010);
        cycle("rol_load");
        drive(3'd7, 1'b1, 1'b1, 3'd3, 1'b0, 4'b0000);
        cycle("rol_accept");
        chk("rol_accept_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            cycle("rol_step");
        end
        chk("rol_end", 32'({bus.done, bus.busy, bus.regval}), 32'h25);
        drive(3'd1, 1'b1, 1'b0, '0, 1'b0, '0);
        cycle("rol_after");

        // Shift-right with inbit fill, paused for two cycles.
        drive(3'd0, 1'b1, 1'b0, '0, 1'b0, 4'b1001);
        cycle("shrin_load");
        drive(3'd4, 1'b1, 1'b1, 3'd2, 1'b1, 4'b0000);
        cycle("shrin_accept");
        drive(3'd4, 1'b1, 1'b0, '0, 1'b1, 4'b0000);
        cycle("shrin_s1");
        chk("shrin_s1_const", 32'({bus.so, bus.regval}), 32'h1C);
        drive(3'd0, 1'b0, 1'b0, '0, 1'b0, 4'b1111);
        repeat (2) cycle("shrin_pause");
        chk("shrin_pause_busy", 32'({bus.busy, bus.regval}), 32'h1C);
        drive(3'd4, 1'b1, 1'b0, '0, 1'b0, 4'b0000);
        cycle("shrin_s2");
        chk("shrin_s2_const", 32'({bus.done, bus.so, bus.regval}), 32'h26);
        drive(3'd1, 1'b1, 1'b0, '0, 1'b0, '0);
        cycle("shrin_after");

        // shamt=0 and start with load.
        drive(3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000);
        cycle("sh0");
        chk("sh0_const", 32'({bus.busy, bus.done, bus.regval}), 32'h16);
        drive(3'd1, 1'b1, 1'b0, '0, 1'b0, '0);
        cycle("sh0_after");
        drive(3'd0, 1'b1, 1'b1, 3'd5, 1'b0, 4'b0011);
        cycle("start_load");
        chk("start_load_const", 32'({bus.busy, bus.done, bus.regval}), 32'h03);

        // Reset in the middle of a long rotate.
        drive(3'd6, 1'b1, 1'b1, 3'd7, 1'b0, 4'b0000);
        cycle("rst_accept");
        drive(3'd1, 1'b1, 1'b0, '0, 1'b0, '0);
        repeat (2) cycle("rst_step");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_model("rst_async");
        @(posedge clk);
        #1;
        chk_model("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd0, 1'b1, 1'b0, '0, 1'b0, 4'b1100);
        cycle("post_rst_load");
        chk("post_rst_const", 32'(bus.regval), 32'hC);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
